sram_port_arbiter: RTL and testbench

- Shares the single group SRAM (spram) between two requesters: the scan-chain interface (scan_for_test SRAM port) and the on-chip core.
- Latches one request per transaction and drives the SRAM until sram_ready.
- Returns read data plus a one-cycle ready pulse to the winning requester.
- A watchdog ends any access the SRAM never acknowledges and flags an error. Sits between scan_for_test/core and spram.

---
 rtl/sram_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for the shared group SRAM: scan-chain port vs. core port.
// One transaction at a time (IDLE -> BUSY -> RESP), with a watchdog that aborts unacknowledged accesses.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned SCAN_PRIO   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_ren,
  input  logic              scan_wen,
  input  logic [ADDR_W-1:0] scan_addr,
  input  logic [DATA_W-1:0] scan_wdata,
  input  logic [1:0]        scan_seg_id,
  input  logic              scan_id_sel,
  output logic [DATA_W-1:0] scan_rdata,
  output logic              scan_ready,
  output logic              scan_err,
  input  logic              core_ren,
  input  logic              core_wen,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [1:0]        core_seg_id,
  input  logic              core_id_sel,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ready,
  output logic              core_err,
  output logic              sram_ren,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [1:0]        sram_seg_id,
  output logic              sram_id_sel,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready,
  output logic              busy,
  output logic              grant_core
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_last_core, w_last_core_nxt;
  logic                r_grant_core, w_grant_core_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_sram_ren, w_sram_ren_nxt;
  logic                r_sram_wen, w_sram_wen_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [1:0]          r_seg_id, w_seg_id_nxt;
  logic                r_id_sel, w_id_sel_nxt;
  logic [DATA_W-1:0]   r_scan_rdata, w_scan_rdata_nxt;
  logic [DATA_W-1:0]   r_core_rdata, w_core_rdata_nxt;
  logic                r_scan_ready, w_scan_ready_nxt;
  logic                r_core_ready, w_core_ready_nxt;
  logic                r_scan_err, w_scan_err_nxt;
  logic                r_core_err, w_core_err_nxt;
  logic [DATA_W-1:0]   w_resp_rdata;
  logic                w_resp_err;

  logic w_req_scan, w_req_core, w_rr_core_turn, w_pick_core;

  assign w_req_scan     = scan_ren | scan_wen;
  assign w_req_core     = core_ren | core_wen;
  // Round-robin: on a tie the core wins only if scan owned the previous transaction
  assign w_rr_core_turn = (SCAN_PRIO == 0) ? ~r_last_core : 1'b0;
  assign w_pick_core    = w_req_core & (~w_req_scan | w_rr_core_turn);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_core_nxt  = r_last_core;
    w_grant_core_nxt = r_grant_core;
    w_busy_nxt       = r_busy;
    w_sram_ren_nxt   = r_sram_ren;
    w_sram_wen_nxt   = r_sram_wen;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_seg_id_nxt     = r_seg_id;
    w_id_sel_nxt     = r_id_sel;
    w_scan_rdata_nxt = r_scan_rdata;
    w_core_rdata_nxt = r_core_rdata;
    w_scan_ready_nxt = 1'b0;
    w_core_ready_nxt = 1'b0;
    w_scan_err_nxt   = 1'b0;
    w_core_err_nxt   = 1'b0;
    w_resp_rdata     = '0;
    w_resp_err       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_req_scan | w_req_core) begin
          w_state_nxt      = S_BUSY;
          w_busy_nxt       = 1'b1;
          w_cnt_nxt        = '0;
          w_grant_core_nxt = w_pick_core;
          w_last_core_nxt  = w_pick_core;
          // A simultaneous ren+wen is treated as a write
          if (w_pick_core) begin
            w_sram_wen_nxt = core_wen;
            w_sram_ren_nxt = ~core_wen;
            w_addr_nxt     = core_addr;
            w_wdata_nxt    = core_wdata;
            w_seg_id_nxt   = core_seg_id;
            w_id_sel_nxt   = core_id_sel;
          end else begin
            w_sram_wen_nxt = scan_wen;
            w_sram_ren_nxt = ~scan_wen;
            w_addr_nxt     = scan_addr;
            w_wdata_nxt    = scan_wdata;
            w_seg_id_nxt   = scan_seg_id;
            w_id_sel_nxt   = scan_id_sel;
          end
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // sram_ready takes precedence over a coincident watchdog expiry
        if (sram_ready || (r_cnt == CNT_MAX)) begin
          w_state_nxt    = S_RESP;
          w_sram_ren_nxt = 1'b0;
          w_sram_wen_nxt = 1'b0;
          w_resp_err     = ~sram_ready;
          w_resp_rdata   = (sram_ready && r_sram_ren) ? sram_rdata : '0;
          if (r_grant_core) begin
            w_core_rdata_nxt = w_resp_rdata;
            w_core_ready_nxt = 1'b1;
            w_core_err_nxt   = w_resp_err;
          end else begin
            w_scan_rdata_nxt = w_resp_rdata;
            w_scan_ready_nxt = 1'b1;
            w_scan_err_nxt   = w_resp_err;
          end
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_last_core  <= 1'b1;
      r_grant_core <= 1'b0;
      r_busy       <= 1'b0;
      r_sram_ren   <= 1'b0;
      r_sram_wen   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_seg_id     <= '0;
      r_id_sel     <= 1'b0;
      r_scan_rdata <= '0;
      r_core_rdata <= '0;
      r_scan_ready <= 1'b0;
      r_core_ready <= 1'b0;
      r_scan_err   <= 1'b0;
      r_core_err   <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_last_core  <= w_last_core_nxt;
      r_grant_core <= w_grant_core_nxt;
      r_busy       <= w_busy_nxt;
      r_sram_ren   <= w_sram_ren_nxt;
      r_sram_wen   <= w_sram_wen_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_seg_id     <= w_seg_id_nxt;
      r_id_sel     <= w_id_sel_nxt;
      r_scan_rdata <= w_scan_rdata_nxt;
      r_core_rdata <= w_core_rdata_nxt;
      r_scan_ready <= w_scan_ready_nxt;
      r_core_ready <= w_core_ready_nxt;
      r_scan_err   <= w_scan_err_nxt;
      r_core_err   <= w_core_err_nxt;
    end
  end

  assign scan_rdata  = r_scan_rdata;
  assign scan_ready  = r_scan_ready;
  assign scan_err    = r_scan_err;
  assign core_rdata  = r_core_rdata;
  assign core_ready  = r_core_ready;
  assign core_err    = r_core_err;
  assign sram_ren    = r_sram_ren;
  assign sram_wen    = r_sram_wen;
  assign sram_addr   = r_addr;
  assign sram_wdata  = r_wdata;
  assign sram_seg_id = r_seg_id;
  assign sram_id_sel = r_id_sel;
  assign busy        = r_busy;
  assign grant_core  = r_grant_core;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: transaction-level model of arbitration, latency, watchdog and data return.
// A second instance with scan priority shares all inputs and is checked during the continuous-tie phase.
module tb_sram_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          scan_ren, scan_wen, scan_id_sel, core_ren, core_wen, core_id_sel;
  logic [AW-1:0] scan_addr, core_addr;
  logic [DW-1:0] scan_wdata, core_wdata, sram_rdata;
  logic [1:0]    scan_seg_id, core_seg_id;
  logic          sram_ready;

  logic [DW-1:0] scan_rdata, core_rdata, sram_wdata;
  logic          scan_ready, scan_err, core_ready, core_err, sram_ren, sram_wen, sram_id_sel, busy, grant_core;
  logic [AW-1:0] sram_addr;
  logic [1:0]    sram_seg_id;

  logic [DW-1:0] p_scan_rdata, p_core_rdata, p_sram_wdata;
  logic          p_scan_ready, p_scan_err, p_core_ready, p_core_err, p_sram_ren, p_sram_wen, p_sram_id_sel, p_busy, p_grant_core;
  logic [AW-1:0] p_sram_addr;
  logic [1:0]    p_sram_seg_id;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO), .SCAN_PRIO(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .scan_ren(scan_ren), .scan_wen(scan_wen), .scan_addr(scan_addr), .scan_wdata(scan_wdata),
    .scan_seg_id(scan_seg_id), .scan_id_sel(scan_id_sel), .scan_rdata(scan_rdata),
    .scan_ready(scan_ready), .scan_err(scan_err),
    .core_ren(core_ren), .core_wen(core_wen), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_seg_id(core_seg_id), .core_id_sel(core_id_sel), .core_rdata(core_rdata),
    .core_ready(core_ready), .core_err(core_err),
    .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_seg_id(sram_seg_id), .sram_id_sel(sram_id_sel), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready), .busy(busy), .grant_core(grant_core)
  );

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO), .SCAN_PRIO(1)) u_dut_prio (
    .clk(clk), .rst_n(rst_n),
    .scan_ren(scan_ren), .scan_wen(scan_wen), .scan_addr(scan_addr), .scan_wdata(scan_wdata),
    .scan_seg_id(scan_seg_id), .scan_id_sel(scan_id_sel), .scan_rdata(p_scan_rdata),
    .scan_ready(p_scan_ready), .scan_err(p_scan_err),
    .core_ren(core_ren), .core_wen(core_wen), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_seg_id(core_seg_id), .core_id_sel(core_id_sel), .core_rdata(p_core_rdata),
    .core_ready(p_core_ready), .core_err(p_core_err),
    .sram_ren(p_sram_ren), .sram_wen(p_sram_wen), .sram_addr(p_sram_addr), .sram_wdata(p_sram_wdata),
    .sram_seg_id(p_sram_seg_id), .sram_id_sel(p_sram_id_sel), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready), .busy(p_busy), .grant_core(p_grant_core)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem     [2048];
  logic [DW-1:0] ref_mem [2048];
  bit            m_last_core;
  logic [DW-1:0] m_scan_rdata, m_core_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_scan(input logic ren, input logic wen, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [1:0] seg, input logic ids);
    scan_ren = ren; scan_wen = wen; scan_addr = a; scan_wdata = d; scan_seg_id = seg; scan_id_sel = ids;
  endtask

  task automatic set_core(input logic ren, input logic wen, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [1:0] seg, input logic ids);
    core_ren = ren; core_wen = wen; core_addr = a; core_wdata = d; core_seg_id = seg; core_id_sel = ids;
  endtask

  // Called at a falling edge in IDLE with requests already driven; returns at the falling edge of the
  // following IDLE cycle. delay >= TO means the SRAM never acknowledges.
  task automatic serve_one(input int delay, input bit hold, input bit chk_p);
    bit            rs, rc, win_core, wr, done, terr, p_core;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [1:0]    e_seg;
    logic          e_ids;
    rs       = scan_ren | scan_wen;
    rc       = core_ren | core_wen;
    win_core = rc && (!rs || !m_last_core);
    p_core   = !rs;
    if (win_core) begin
      wr = core_wen; e_addr = core_addr; e_wdata = core_wdata; e_seg = core_seg_id; e_ids = core_id_sel;
    end else begin
      wr = scan_wen; e_addr = scan_addr; e_wdata = scan_wdata; e_seg = scan_seg_id; e_ids = scan_id_sel;
    end
    m_last_core = win_core;
    @(posedge clk); @(negedge clk);
    done = 1'b0;
    for (int k = 0; k < TO && !done; k++) begin
      chk("busy_in_busy", busy, 1);
      chk("grant_core", grant_core, win_core);
      chk("sram_ren", sram_ren, !wr);
      chk("sram_wen", sram_wen, wr);
      chk("sram_addr", sram_addr, e_addr);
      chk("sram_wdata", sram_wdata, e_wdata);
      chk("sram_seg_id", sram_seg_id, e_seg);
      chk("sram_id_sel", sram_id_sel, e_ids);
      chk("ready_in_busy", {scan_ready, core_ready}, 0);
      if (chk_p) chk("prio_grant_core", p_grant_core, p_core);
      if (k == 0) begin
        if (win_core) begin core_addr = AW'($urandom); core_wdata = $urandom; end
        else          begin scan_addr = AW'($urandom); scan_wdata = $urandom; end
      end
      if (k == delay) begin
        sram_ready = 1'b1;
        if (sram_wen) begin mem[sram_addr] = sram_wdata; sram_rdata = $urandom; end
        else          sram_rdata = mem[sram_addr];
        done = 1'b1;
      end
      @(posedge clk); @(negedge clk);
    end
    sram_ready = 1'b0;
    terr = !done;
    if (terr)    e_rdata = '0;
    else if (wr) begin e_rdata = '0; ref_mem[e_addr] = e_wdata; end
    else         e_rdata = ref_mem[e_addr];
    if (win_core) m_core_rdata = e_rdata; else m_scan_rdata = e_rdata;
    chk("scan_ready", scan_ready, !win_core);
    chk("core_ready", core_ready, win_core);
    chk("scan_err", scan_err, !win_core && terr);
    chk("core_err", core_err, win_core && terr);
    chk("scan_rdata", scan_rdata, m_scan_rdata);
    chk("core_rdata", core_rdata, m_core_rdata);
    chk("sram_req_clr", {sram_ren, sram_wen}, 0);
    chk("busy_in_resp", busy, 1);
    if (chk_p) begin
      chk("prio_scan_ready", p_scan_ready, !p_core);
      chk("prio_core_ready", p_core_ready, p_core);
    end
    if (!hold) begin
      if (win_core) begin core_ren = 1'b0; core_wen = 1'b0; end
      else          begin scan_ren = 1'b0; scan_wen = 1'b0; end
    end
    @(posedge clk); @(negedge clk);
    chk("resp_clr", {scan_ready, core_ready, scan_err, core_err}, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    logic [1:0] op;
    bit         do_s, do_c;
    int         dly;
    rst_n = 1'b0;
    set_scan(0, 0, '0, '0, '0, 0);
    set_core(0, 0, '0, '0, '0, 0);
    sram_ready = 1'b0;
    sram_rdata = '0;
    for (int i = 0; i < 2048; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    m_last_core = 1'b1; m_scan_rdata = '0; m_core_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {busy, grant_core, sram_ren, sram_wen}, 0);
    chk("rst_ready", {scan_ready, core_ready, scan_err, core_err}, 0);
    chk("rst_rdata", {scan_rdata, core_rdata}, 0);
    chk("rst_sram_bus", {sram_addr, sram_wdata, sram_seg_id, sram_id_sel}, 0);
    chk("rst_prio", {p_busy, p_grant_core, p_sram_ren, p_scan_ready, p_core_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single scan read, answered after two BUSY cycles
    mem[5] = 32'hA5A5_0001; ref_mem[5] = 32'hA5A5_0001;
    set_scan(1, 0, 11'h005, 32'hDEAD_BEEF, 2'b01, 1);
    serve_one(2, 0, 0);
    chk("scan_read_value", scan_rdata, 32'hA5A5_0001);

    // Core write to the top address, then read it back
    set_core(0, 1, 11'h7FF, 32'h1234_5678, 2'b10, 0);
    serve_one(3, 0, 0);
    set_core(1, 0, 11'h7FF, 32'h0, 2'b10, 0);
    serve_one(1, 0, 0);
    chk("core_readback", core_rdata, 32'h1234_5678);

    // ren+wen together is a write
    set_core(1, 1, 11'h100, 32'hCAFE_F00D, 2'b11, 1);
    serve_one(0, 0, 0);
    set_scan(1, 0, 11'h100, 32'h0, 2'b00, 0);
    serve_one(0, 0, 0);
    chk("both_bits_write", scan_rdata, 32'hCAFE_F00D);

    // Both ports requesting continuously: round-robin vs. scan priority
    set_scan(1, 0, 11'h010, 32'h0, 2'b00, 0);
    set_core(1, 0, 11'h020, 32'h0, 2'b01, 1);
    for (int i = 0; i < 4; i++) serve_one(i % 2, 1, 1);
    set_scan(0, 0, '0, '0, '0, 0);
    set_core(0, 0, '0, '0, '0, 0);
    @(negedge clk);

    // Watchdog: dead SRAM, ready on the very last allowed cycle, then normal service
    set_core(1, 0, 11'h033, 32'h0, 2'b00, 0);
    serve_one(1000, 0, 0);
    chk("timeout_rdata", core_rdata, 0);
    set_core(1, 0, 11'h034, 32'h0, 2'b00, 0);
    serve_one(TO - 1, 0, 0);
    set_scan(0, 1, 11'h035, 32'h5555_AAAA, 2'b01, 0);
    serve_one(1000, 0, 0);
    set_scan(1, 0, 11'h035, 32'h0, 2'b01, 0);
    serve_one(0, 0, 0);

    // Randomized traffic, loser of a tie served next
    for (int it = 0; it < 40; it++) begin
      do_s = 1'($urandom); do_c = 1'($urandom);
      if (!do_s && !do_c) do_c = 1'b1;
      if (do_s) begin
        op = 2'($urandom_range(1, 3));
        set_scan(op[0], op[1], AW'($urandom_range(0, 15)), $urandom, 2'($urandom), 1'($urandom));
      end
      if (do_c) begin
        op = 2'($urandom_range(1, 3));
        set_core(op[0], op[1], AW'($urandom_range(0, 15)), $urandom, 2'($urandom), 1'($urandom));
      end
      dly = ($urandom_range(0, 15) == 0) ? 1000 : int'($urandom_range(0, 4));
      serve_one(dly, 0, 0);
      if (scan_ren | scan_wen | core_ren | core_wen) serve_one(int'($urandom_range(0, 3)), 0, 0);
    end

    // Reset in the middle of a transaction
    set_scan(1, 0, 11'h044, 32'h0, 2'b00, 0);
    @(posedge clk); @(negedge clk);
    chk("pre_rst_busy", {busy, sram_ren}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_drop", {busy, sram_ren, sram_wen, grant_core}, 0);
    set_scan(0, 0, '0, '0, '0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last_core = 1'b1; m_scan_rdata = '0; m_core_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      chk("no_ready_after_rst", {scan_ready, core_ready, busy}, 0);
      @(negedge clk);
    end
    set_scan(1, 0, 11'h050, 32'h0, 2'b00, 0);
    set_core(1, 0, 11'h060, 32'h0, 2'b00, 0);
    serve_one(1, 0, 0);
    chk("first_tie_scan", grant_core, 0);
    serve_one(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
